// File: rtl/beam_sum_sequencer.sv
// Serial channel summer: accumulates NUM_CH signed samples per frame with one adder
// and hands the frame sum off on a valid/ready output. Optional channel mask via BEAM_CHMASK_EN.
module beam_sum_sequencer #(
    parameter int NUM_CH = 8,
    parameter int IN_W   = 19,
    parameter int OUT_W  = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
`ifdef BEAM_CHMASK_EN
    input  logic [NUM_CH-1:0] ch_mask,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sum,
    output logic              ovf,
    output logic              busy,
    output logic [3:0]        ch_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);

    state_t           state;
    state_t           next_state;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] sample_ext;
    logic [OUT_W-1:0] addend;
    logic [OUT_W-1:0] sum;
    logic             beat;
    logic             last_beat;
    logic             add_ovf;

`ifdef BEAM_CHMASK_EN
    logic [NUM_CH-1:0] mask_q;
    logic [15:0]       mask_ext;
    assign mask_ext = 16'(mask_q);
    assign addend   = mask_ext[ch_idx] ? sample_ext : '0;
`else
    assign addend   = sample_ext;
`endif

    assign sample_ext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign sum        = acc + addend;
    assign add_ovf    = (acc[OUT_W-1] == addend[OUT_W-1]) && (sum[OUT_W-1] != acc[OUT_W-1]);
    assign beat       = in_valid && (state == ACCUM);
    assign last_beat  = beat && (ch_idx == LAST_IDX);

    // All handshake/status outputs decode directly from the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = ACCUM;
                ACCUM:   if (last_beat) next_state = HOLD;
                HOLD:    if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Abort clears the partial frame; out_sum keeps the last handed-off value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ch_idx  <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
`ifdef BEAM_CHMASK_EN
            mask_q  <= '0;
`endif
        end else if (abort) begin
            acc    <= '0;
            ch_idx <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        ch_idx <= '0;
                        ovf    <= 1'b0;
`ifdef BEAM_CHMASK_EN
                        mask_q <= ch_mask;
`endif
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= sum;
                        if (add_ovf) begin
                            ovf <= 1'b1;
                        end
                        if (last_beat) begin
                            out_sum <= sum;
                            ch_idx  <= '0;
                        end else begin
                            ch_idx <= ch_idx + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
